mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ramWidth, default 8, meaning the data word width.
REQ-002 SHALL have parameter addrSize, default 8, meaning the address width.
REQ-003 SHALL have parameter timeoutCycles, default 64, meaning the maximum number of WAIT cycles before abort.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports req0/req1, input, 1 bit each: port 0 (fetch) and port 1 (data) request, held high until ack.
REQ-007 SHALL have ports wr0/wr1, input, 1 bit each: 1 means write, 0 means read.
REQ-008 SHALL have ports ind0/ind1, input, 1 bit each: indirect-access flag per port.
REQ-009 SHALL have ports addr0/addr1, input, addrSize bits each: request addresses.
REQ-010 SHALL have ports wdata0/wdata1, input, ramWidth bits each: write data.
REQ-011 SHALL have ports ack0/ack1, output, 1 bit each: one-cycle completion pulse.
REQ-012 SHALL have ports err0/err1, output, 1 bit each: one-cycle timeout pulse, coincident with ack.
REQ-013 SHALL have port rdata, output, ramWidth bits: registered read data, valid while ack is high.
REQ-014 SHALL have port memCntrl, output, 2 bits, driven to the memory module: 00 idle, 01 read, 10 write, 11 never driven.
REQ-015 SHALL have ports memAddr (output, addrSize bits), memDataIn (output, ramWidth bits) and memIndirect (output, 1 bit).
REQ-016 SHALL have ports memDataOut (input, ramWidth bits) and memReady (input, 1 bit) from the memory module.
REQ-017 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-018 SHALL implement an FSM with states IDLE, ISSUE, WAIT and DONE.
REQ-019 SHALL, in IDLE, select a winner when any request is high, latch its wr, ind, addr and wdata, and go to ISSUE on the next edge.
REQ-020 SHALL, in ISSUE, drive memCntrl to 01 or 10 with the latched operands for exactly one cycle, then go to WAIT.
REQ-021 SHALL, in WAIT, hold memCntrl and all operands stable and increment a wait counter every cycle.
REQ-022 SHALL, on memReady high in WAIT, capture memDataOut into rdata and go to DONE; reads and writes are handled the same way.
REQ-023 SHALL, when the wait counter reaches timeoutCycles-1 without memReady, go to DONE with the error flag set and rdata unchanged.
REQ-024 SHALL, in DONE, pulse ack and err only for the winning port, drive memCntrl to 00, and return to IDLE; the minimum request-to-ack latency is therefore 4 cycles.
REQ-025 SHALL drive memCntrl to 00 in IDLE and DONE.
REQ-026 SHALL ignore memReady outside WAIT.
REQ-027 SHALL ignore changes to requester inputs after latching until ack.
REQ-028 SHALL, when a requester drops req before ack, still complete the access but suppress that port's ack and err.
REQ-029 SHALL, when both requests are high in IDLE, apply the priority rule in REQ-034/REQ-035.
REQ-030 SHALL re-arbitrate only in IDLE, with no back-to-back grant in DONE, so there is at least one idle cycle between accesses.
REQ-031 SHALL size the wait counter at $clog2(timeoutCycles)+1 bits and clear it on entry to ISSUE.

Reset
REQ-032 SHALL, while clr is high at a rising edge, force state to IDLE and clear the following, taking priority over everything else including an in-flight WAIT: ack0, ack1, err0, err1, busy, memCntrl, memAddr, memDataIn, memIndirect, rdata, the wait counter and the last-grant pointer.
REQ-033 SHALL, after a mid-access reset, leave no pending ack for the aborted request; the requester re-requests.

Configuration
REQ-034 SHALL, when macro MEM_ARB_ROUND_ROBIN_EN is defined, grant on a tie the port not granted last, with the pointer after reset favouring port 1.
REQ-035 SHALL, when MEM_ARB_ROUND_ROBIN_EN is undefined, always give port 1 (data) fixed priority over port 0 on a tie, with no pointer logic.

Verification
REQ-036 SHALL be verified by: req0 read at addr 0x12 with memReady high in the third WAIT cycle and memDataOut=0xA5 -> ack0 with rdata=0xA5, memCntrl=01 throughout ISSUE and WAIT.
REQ-037 SHALL be verified by: req1 write of 0x3C to 0x40 with ind1=1 -> memCntrl=10, memAddr=0x40, memDataIn=0x3C, memIndirect=1 until memReady, then ack1.
REQ-038 SHALL be verified by: req0 and req1 held high for four accesses -> with the macro, grants 1,0,1,0; without it, grants 1,1,1,1.
REQ-039 SHALL be verified by: memReady never asserted with timeoutCycles=64 -> ack0 and err0 pulse together after 64 WAIT cycles, and memCntrl returns to 00.
REQ-040 SHALL be verified by: clr asserted during WAIT -> next cycle busy=0, memCntrl=00 and no ack; a later memReady pulse is ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: fetch (port 0) and data (port 1) share one memory through an IDLE/ISSUE/WAIT/DONE handshake.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 1 wins every tie.
module mem_port_arbiter #(
    parameter int ramWidth      = 8,
    parameter int addrSize      = 8,
    parameter int timeoutCycles = 64
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                req0,
    input  logic                req1,
    input  logic                wr0,
    input  logic                wr1,
    input  logic                ind0,
    input  logic                ind1,
    input  logic [addrSize-1:0] addr0,
    input  logic [addrSize-1:0] addr1,
    input  logic [ramWidth-1:0] wdata0,
    input  logic [ramWidth-1:0] wdata1,
    output logic                ack0,
    output logic                ack1,
    output logic                err0,
    output logic                err1,
    output logic [ramWidth-1:0] rdata,
    output logic [1:0]          memCntrl,
    output logic [addrSize-1:0] memAddr,
    output logic [ramWidth-1:0] memDataIn,
    output logic                memIndirect,
    input  logic [ramWidth-1:0] memDataOut,
    input  logic                memReady,
    output logic                busy
);

    localparam int CntW = $clog2(timeoutCycles) + 1;
    localparam logic [CntW-1:0] LastWait = CntW'(timeoutCycles - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] CNTRL_IDLE  = 2'b00;
    localparam logic [1:0] CNTRL_READ  = 2'b01;
    localparam logic [1:0] CNTRL_WRITE = 2'b10;

    logic [1:0]      state;
    logic [CntW-1:0] wait_cnt;
    logic            grant;
    logic            dropped;
    logic            pick;
    logic            winner_req;
    logic            live;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // Reset value 0 means "port 0 went last", so the first tie goes to port 1.
    always_comb begin
        pick = req1;
        if (req0 && req1) pick = ~last_grant;
    end
`else
    always_comb begin
        pick = req1;
    end
`endif

    assign winner_req = grant ? req1 : req0;
    // A requester that let go of req at any point before completion gets no ack/err.
    assign live       = winner_req & ~dropped;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            memCntrl    <= CNTRL_IDLE;
            memAddr     <= '0;
            memDataIn   <= '0;
            memIndirect <= 1'b0;
            rdata       <= '0;
            wait_cnt    <= '0;
            grant       <= 1'b0;
            dropped     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant  <= 1'b0;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant       <= pick;
                        memCntrl    <= (pick ? wr1 : wr0) ? CNTRL_WRITE : CNTRL_READ;
                        memAddr     <= pick ? addr1 : addr0;
                        memDataIn   <= pick ? wdata1 : wdata0;
                        memIndirect <= pick ? ind1 : ind0;
                        wait_cnt    <= '0;
                        dropped     <= 1'b0;
                        state       <= ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant  <= pick;
`endif
                    end
                end
                ISSUE: begin
                    if (!winner_req) dropped <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (!winner_req) dropped <= 1'b1;
                    wait_cnt <= wait_cnt + 1'b1;
                    if (memReady) begin
                        rdata    <= memDataOut;
                        memCntrl <= CNTRL_IDLE;
                        ack0     <= live & ~grant;
                        ack1     <= live & grant;
                        state    <= DONE;
                    end else if (wait_cnt == LastWait) begin
                        memCntrl <= CNTRL_IDLE;
                        ack0     <= live & ~grant;
                        ack1     <= live & grant;
                        err0     <= live & ~grant;
                        err1     <= live & grant;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter; the bench plays the memory and compares against a
// transaction-level model of grants, latency, captured data and timeouts.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       clr, req0, req1, wr0, wr1, ind0, ind1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, err0, err1;
    logic [7:0] rdata;
    logic [1:0] memCntrl;
    logic [7:0] memAddr, memDataIn;
    logic       memIndirect;
    logic [7:0] memDataOut;
    logic       memReady;
    logic       busy;

    int checks = 0;
    int failures = 0;

    // Model state: last granted port (0 after reset, so a tie favours port 1) and held rdata.
    int         model_last = 0;
    logic [7:0] model_rdata = 8'h00;

    // Observations from one access.
    int         ack_cyc, end_cyc, ack_count, err_count;
    logic       a0, a1, e0, e1, iss_ind, iss_busy, stable;
    logic [1:0] iss_cntrl, done_cntrl, end_cntrl;
    logic [7:0] iss_addr, iss_wdata, ack_rdata, end_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ramWidth(8), .addrSize(8), .timeoutCycles(TIMEOUT)) dut (
        .clk(clk), .clr(clr), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .ind0(ind0), .ind1(ind1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0), .ack1(ack1),
        .err0(err0), .err1(err1), .rdata(rdata), .memCntrl(memCntrl),
        .memAddr(memAddr), .memDataIn(memDataIn), .memIndirect(memIndirect),
        .memDataOut(memDataOut), .memReady(memReady), .busy(busy)
    );

    function automatic int model_pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return (model_last == 0) ? 1 : 0;
`else
            return 1;
`endif
        end
        return r1 ? 1 : 0;
    endfunction

    // Starts at an IDLE negedge with requests already driven; plays memory, raising memReady in
    // WAIT cycle k (1-based) when ready_en; returns at the first IDLE negedge after the access.
    task automatic do_access(input int k, input bit ready_en, input logic [7:0] mem_val,
                             input bit noise, input bit scramble, input int drop_at);
        ack_cyc = 0; end_cyc = 0; ack_count = 0; err_count = 0; stable = 1'b1;
        a0 = 0; a1 = 0; e0 = 0; e1 = 0; done_cntrl = 2'bxx; end_cntrl = 2'bxx;
        for (int cyc = 1; cyc <= k + 6; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                iss_cntrl = memCntrl; iss_addr = memAddr; iss_wdata = memDataIn;
                iss_ind = memIndirect; iss_busy = busy;
            end else if (cyc <= k + 1) begin
                if (memCntrl !== iss_cntrl || memAddr !== iss_addr ||
                    memDataIn !== iss_wdata || memIndirect !== iss_ind) stable = 1'b0;
            end
            if (ack0 === 1'b1) ack_count++;
            if (ack1 === 1'b1) ack_count++;
            if (err0 === 1'b1) err_count++;
            if (err1 === 1'b1) err_count++;
            if (ack_cyc == 0 && (ack0 === 1'b1 || ack1 === 1'b1)) begin
                ack_cyc = cyc; a0 = ack0; a1 = ack1; e0 = err0; e1 = err1; ack_rdata = rdata;
            end
            if (cyc == k + 2) done_cntrl = memCntrl;
            if (cyc >= 2 && busy === 1'b0) begin
                end_cyc = cyc; end_cntrl = memCntrl; end_rdata = rdata;
                break;
            end
            if (cyc == drop_at) begin req0 = 1'b0; req1 = 1'b0; end
            if (scramble && cyc == 1) begin
                wr0 = 1'($urandom); wr1 = 1'($urandom); ind0 = 1'($urandom); ind1 = 1'($urandom);
                addr0 = 8'($urandom); addr1 = 8'($urandom);
                wdata0 = 8'($urandom); wdata1 = 8'($urandom);
            end
            memReady   = (ready_en && cyc == k + 1) || (noise && cyc == 1);
            memDataOut = (ready_en && cyc == k + 1) ? mem_val : 8'($urandom);
        end
        memReady = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack0, ack1, err0, err1, busy, memIndirect} !== 6'b0) begin
            failures++; $display("FAIL reset_flags got=%b want=000000", {ack0, ack1, err0, err1, busy, memIndirect});
        end
        checks++;
        if (memCntrl !== 2'b00) begin failures++; $display("FAIL reset_memCntrl got=%b want=00", memCntrl); end
        checks++;
        if ({memAddr, memDataIn, rdata} !== 24'h0) begin
            failures++; $display("FAIL reset_data got=%h want=000000", {memAddr, memDataIn, rdata});
        end
        clr = 1'b0;
        model_last = 0; model_rdata = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_read();
        req0 = 1'b1; wr0 = 1'b0; ind0 = 1'b0; addr0 = 8'h12; wdata0 = 8'h77;
        do_access(3, 1'b1, 8'hA5, 1'b0, 1'b0, 0);
        req0 = 1'b0;
        model_last = 0; model_rdata = 8'hA5;
        checks++;
        if (ack_cyc != 5 || a0 !== 1'b1 || a1 !== 1'b0) begin
            failures++; $display("FAIL read_ack got=cyc%0d a0=%b a1=%b want=cyc5 a0=1 a1=0", ack_cyc, a0, a1);
        end
        checks++;
        if (ack_rdata !== 8'hA5) begin failures++; $display("FAIL read_rdata got=%h want=a5", ack_rdata); end
        checks++;
        if (iss_cntrl !== 2'b01 || iss_addr !== 8'h12 || !stable) begin
            failures++; $display("FAIL read_issue got=cntrl%b addr%h stable%b want=cntrl01 addr12 stable1", iss_cntrl, iss_addr, stable);
        end
        checks++;
        if (done_cntrl !== 2'b00 || e0 !== 1'b0) begin
            failures++; $display("FAIL read_done got=cntrl%b err%b want=cntrl00 err0", done_cntrl, e0);
        end
    endtask

    task automatic test_write_indirect();
        req1 = 1'b1; wr1 = 1'b1; ind1 = 1'b1; addr1 = 8'h40; wdata1 = 8'h3C;
        do_access(2, 1'b1, 8'h5E, 1'b0, 1'b1, 0);
        req1 = 1'b0;
        model_last = 1; model_rdata = 8'h5E;
        checks++;
        if (iss_cntrl !== 2'b10 || iss_addr !== 8'h40 || iss_wdata !== 8'h3C || iss_ind !== 1'b1) begin
            failures++; $display("FAIL write_issue got=%b/%h/%h/%b want=10/40/3c/1", iss_cntrl, iss_addr, iss_wdata, iss_ind);
        end
        checks++;
        if (!stable) begin failures++; $display("FAIL write_stable got=0 want=1"); end
        checks++;
        if (ack_cyc != 4 || a1 !== 1'b1 || a0 !== 1'b0 || ack_count != 1) begin
            failures++; $display("FAIL write_ack got=cyc%0d a1=%b a0=%b n=%0d want=cyc4 a1=1 a0=0 n=1", ack_cyc, a1, a0, ack_count);
        end
    endtask

    task automatic test_priority();
        int exp_port;
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        model_last = 0; model_rdata = 8'h00;
        req0 = 1'b1; wr0 = 1'b0; ind0 = 1'b0; addr0 = 8'h01;
        req1 = 1'b1; wr1 = 1'b0; ind1 = 1'b0; addr1 = 8'h81;
        for (int n = 0; n < 4; n++) begin
            logic [7:0] v;
            int k;
            v = 8'($urandom); k = $urandom_range(1, 3);
            exp_port = model_pick(1'b1, 1'b1);
            do_access(k, 1'b1, v, 1'b0, 1'b0, 0);
            model_last = exp_port; model_rdata = v;
            checks++;
            if ({a1, a0} !== ((exp_port == 1) ? 2'b10 : 2'b01) || iss_addr !== ((exp_port == 1) ? 8'h81 : 8'h01)) begin
                failures++; $display("FAIL prio_grant%0d got=a1a0=%b addr=%h want_port=%0d", n, {a1, a0}, iss_addr, exp_port);
            end
            checks++;
            if (end_cyc != k + 3 || end_cntrl !== 2'b00) begin
                failures++; $display("FAIL prio_idle_gap%0d got=cyc%0d cntrl%b want=cyc%0d cntrl00", n, end_cyc, end_cntrl, k + 3);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_timeout();
        req0 = 1'b1; wr0 = 1'b0; ind0 = 1'b0; addr0 = 8'h33;
        do_access(TIMEOUT, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        req0 = 1'b0;
        model_last = 0;
        checks++;
        if (ack_cyc != TIMEOUT + 2 || a0 !== 1'b1 || e0 !== 1'b1 || e1 !== 1'b0) begin
            failures++; $display("FAIL timeout_ack got=cyc%0d a0=%b e0=%b e1=%b want=cyc%0d 1 1 0", ack_cyc, a0, e0, e1, TIMEOUT + 2);
        end
        checks++;
        if (ack_rdata !== model_rdata || done_cntrl !== 2'b00 || !stable) begin
            failures++; $display("FAIL timeout_state got=rdata%h cntrl%b stable%b want=rdata%h cntrl00 stable1", ack_rdata, done_cntrl, stable, model_rdata);
        end
    endtask

    task automatic test_drop_req();
        req0 = 1'b1; wr0 = 1'b0; ind0 = 1'b1; addr0 = 8'h55;
        do_access(3, 1'b1, 8'hC3, 1'b0, 1'b0, 2);
        model_last = 0; model_rdata = 8'hC3;
        checks++;
        if (ack_count != 0 || err_count != 0) begin
            failures++; $display("FAIL drop_suppress got=acks%0d errs%0d want=0 0", ack_count, err_count);
        end
        checks++;
        if (end_cyc != 6 || end_rdata !== 8'hC3) begin
            failures++; $display("FAIL drop_complete got=cyc%0d rdata%h want=cyc6 rdata=c3", end_cyc, end_rdata);
        end
    endtask

    task automatic test_clr_mid_wait();
        bit stray;
        req0 = 1'b1; wr0 = 1'b0; ind0 = 1'b0; addr0 = 8'h99;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; req0 = 1'b0;
        model_last = 0; model_rdata = 8'h00;
        checks++;
        if (busy !== 1'b0 || memCntrl !== 2'b00 || ack0 !== 1'b0 || rdata !== 8'h00) begin
            failures++; $display("FAIL clr_abort got=busy%b cntrl%b ack%b rdata%h want=0 00 0 00", busy, memCntrl, ack0, rdata);
        end
        stray = 1'b0;
        for (int i = 0; i < 5; i++) begin
            memReady = (i == 0); memDataOut = 8'hEE;
            @(negedge clk);
            if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0 || rdata !== 8'h00) stray = 1'b1;
        end
        memReady = 1'b0;
        checks++;
        if (stray) begin failures++; $display("FAIL clr_no_pending got=activity want=none"); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int r, k, wp;
            logic [7:0] v, ea, ed;
            logic ew, ei;
            r = $urandom_range(1, 3); k = $urandom_range(1, 6); v = 8'($urandom);
            req0 = r[0]; req1 = r[1];
            wr0 = 1'($urandom); wr1 = 1'($urandom); ind0 = 1'($urandom); ind1 = 1'($urandom);
            addr0 = 8'($urandom); addr1 = 8'($urandom); wdata0 = 8'($urandom); wdata1 = 8'($urandom);
            wp = model_pick(r[0], r[1]);
            ew = (wp == 1) ? wr1 : wr0;     ei = (wp == 1) ? ind1 : ind0;
            ea = (wp == 1) ? addr1 : addr0; ed = (wp == 1) ? wdata1 : wdata0;
            do_access(k, 1'b1, v, 1'($urandom), 1'($urandom), 0);
            req0 = 1'b0; req1 = 1'b0;
            model_last = wp; model_rdata = v;
            checks++;
            if ({a1, a0} !== ((wp == 1) ? 2'b10 : 2'b01) || ack_cyc != k + 2 || ack_count != 1 || err_count != 0) begin
                failures++; $display("FAIL rand%0d_ack got=a1a0=%b cyc%0d n%0d e%0d want_port=%0d cyc%0d", n, {a1, a0}, ack_cyc, ack_count, err_count, wp, k + 2);
            end
            checks++;
            if (iss_cntrl !== (ew ? 2'b10 : 2'b01) || iss_addr !== ea || iss_wdata !== ed || iss_ind !== ei || !stable || iss_busy !== 1'b1) begin
                failures++; $display("FAIL rand%0d_ops got=%b/%h/%h/%b st%b want=%b/%h/%h/%b", n, iss_cntrl, iss_addr, iss_wdata, iss_ind, stable, ew ? 2'b10 : 2'b01, ea, ed, ei);
            end
            checks++;
            if (ack_rdata !== v || end_cyc != k + 3) begin
                failures++; $display("FAIL rand%0d_data got=%h cyc%0d want=%h cyc%0d", n, ack_rdata, end_cyc, v, k + 3);
            end
        end
    endtask

    initial begin
        clr = 1'b1; req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0; ind0 = 1'b0; ind1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; memDataOut = '0; memReady = 1'b0;
        test_reset();
        test_read();
        test_write_indirect();
        test_priority();
        test_timeout();
        test_drop_req();
        test_clr_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
